// File: rtl/sum_accumulator.sv
// Burst accumulator for {cout, sum} adder results with valid/ready on both sides.
// Define SUM_ACCUMULATOR_SAT_EN to saturate the total on overflow instead of wrapping.

package sum_accumulator_pkg;
    localparam int unsigned SUM_W  = 16;
    localparam int unsigned WORD_W = SUM_W + 1;

    // One adder result as presented on the input handshake
    typedef struct packed {
        logic             cout;
        logic [SUM_W-1:0] sum;
    } adder_word_t;
endpackage

module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int unsigned COUNT_W = 4,
    parameter int unsigned ACC_W   = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SUM_W-1:0]   in_sum,
    input  logic               in_cout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_total,
    output logic               out_ovf,
    output logic               busy
);

    localparam int unsigned ADD_W = ACC_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic               ovf;
    logic               ovf_next;
    logic [COUNT_W-1:0] remaining;
    logic [COUNT_W-1:0] remaining_next;

    adder_word_t        word_c;
    logic [ADD_W-1:0]   add_c;
    logic               in_xfer_c;
    logic               out_xfer_c;

    // Extra top bit of the add captures the accumulator carry-out
    assign word_c     = adder_word_t'({in_cout, in_sum});
    assign add_c      = {1'b0, acc} + ADD_W'(word_c);
    assign in_xfer_c  = in_valid && in_ready;
    assign out_xfer_c = out_valid && out_ready;

    // Next-state and datapath update
    always_comb begin
        state_next     = state;
        acc_next       = acc;
        ovf_next       = ovf;
        remaining_next = remaining;

        case (state)
            IDLE: begin
                if (start) begin
                    acc_next       = '0;
                    ovf_next       = 1'b0;
                    remaining_next = len;
                    state_next     = (len != '0) ? ACCUM : DONE;
                end
            end

            ACCUM: begin
                if (in_xfer_c) begin
`ifdef SUM_ACCUMULATOR_SAT_EN
                    acc_next = add_c[ACC_W] ? '1 : add_c[ACC_W-1:0];
`else
                    acc_next = add_c[ACC_W-1:0];
`endif
                    ovf_next       = ovf | add_c[ACC_W];
                    remaining_next = remaining - COUNT_W'(1);
                    if (remaining == COUNT_W'(1)) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                if (out_xfer_c) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            ovf       <= 1'b0;
            remaining <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            acc       <= acc_next;
            ovf       <= ovf_next;
            remaining <= remaining_next;
            in_ready  <= (state_next == ACCUM);
            out_valid <= (state_next == DONE);
            busy      <= (state_next != IDLE);
        end
    end

    assign out_total = acc;
    assign out_ovf   = ovf;

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 16-bit adder stage: accepts a burst of `{cout, sum}` results over a valid/ready handshake and accumulates them into a wide running total. A `start` pulse fixes the burst length. After the last word is accepted, the block presents the total and a sticky overflow flag on an output valid/ready handshake. It sits between the adder datapath and any result sink (register file, bus slave).

## Interface
- `COUNT_W`, default 4: width of the burst-length field; bursts of 0 to 2^COUNT_W-1 words.
- `ACC_W`, default 24: accumulator and total width; must be ≥ 17.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `start`  in  1  single-cycle request to begin a burst; sampled only in IDLE.
- `len`  in  COUNT_W  number of words in the burst; sampled with `start`.
- `in_valid`  in  1  adder result is valid.
- `in_ready`  out  1  block accepts a word this cycle.
- `in_sum`  in  16  adder sum.
- `in_cout`  in  1  adder carry-out; forms bit 16 of the word.
- `out_valid`  out  1  total is valid.
- `out_ready`  in  1  sink accepts the total.
- `out_total`  out  ACC_W  accumulated total.
- `out_ovf`  out  1  total exceeded 2^ACC_W-1 at some point in the burst.
- `busy`  out  1  block is in ACCUM or DONE.

## Operation
- **Word value:** each word is the 17-bit unsigned value `{in_cout, in_sum}`, zero-extended to ACC_W bits.
- **Transfer rules:**
  - An input transfer occurs when `in_valid && in_ready`.
  - An output transfer occurs when `out_valid && out_ready`.
- **IDLE:**
  - `in_ready=0`, `out_valid=0`.
  - On `start`: accumulator is cleared, `ovf` is cleared, `remaining` is loaded from `len`.
  - If `len != 0`, go to ACCUM. If `len == 0`, go to DONE with total 0 and ovf 0.
- **ACCUM:**
  - `in_ready=1`.
  - On each input transfer: `acc <= acc + word`, `remaining <= remaining - 1`.
  - If the ACC_W-bit add carries out, `ovf` is set; it is sticky until the next `start`.
  - When the accepted word has `remaining == 1`, go to DONE.
- **DONE:**
  - `out_valid=1`; `out_total=acc`; `out_ovf=ovf`.
  - Outputs hold stable until the output transfer, then go to IDLE.
- **start outside IDLE:** `start` in ACCUM or DONE is ignored; there is no queuing.
- **Stray inputs:** `in_valid` in IDLE or DONE is ignored. `in_ready=0` there, so no transfer occurs.
- **`busy`:** equals `(state != IDLE)`.
- **`out_total` outside DONE:** holds the last accumulator value; sinks ignore it when `out_valid=0`.

## Timing
- **Reset values** (asynchronous on `rst_n=0`, regardless of state, including mid-burst): state=IDLE, `acc=0`, `ovf=0`, `remaining=0`, `in_ready=0`, `out_valid=0`, `out_total=0`, `out_ovf=0`, `busy=0`. A partial burst is discarded.
- **Handshake outputs:** `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready`.
- **Start latency:** `start` at edge k puts the block in ACCUM (`in_ready=1`) from cycle k+1.
- **Throughput:** one word per cycle while `in_valid` stays high.
- **Result latency:** last word accepted at edge k gives `out_valid=1` and the final `out_total` from cycle k+1.
- **Return to idle:** output transfer at edge k gives IDLE at cycle k+1. A new `start` is sampled at edge k+1 at the earliest.
- **Zero-length burst:** `start` with `len=0` gives `out_valid=1` in the next cycle.

## Configuration
- Macro: `SUM_ACCUMULATOR_SAT_EN`.
- **Defined:** on overflow, `acc` saturates to all-ones (2^ACC_W-1) and stays saturated for the rest of the burst; `ovf` is set.
- **Undefined:** `acc` wraps modulo 2^ACC_W; `ovf` is still set and sticky.

## Test plan
- **Normal burst:** reset, `len=3`, words 0x01FE/cout0, 0xFFFF/cout1, 0x0001/cout0 on consecutive cycles -> `out_valid` one cycle after the 3rd word, `out_total=0x0201FE`, `out_ovf=0`.
- **Backpressure and gaps:** `len=2`, `in_valid` gaps between words, `out_ready` held low 5 cycles -> total is correct; `out_valid`, `out_total` and `out_ovf` stay stable until `out_ready`, then IDLE next cycle.
- **Overflow:** ACC_W=18, `len=3`, three words of 0xFFFF/cout1 ->
  - without macro: `out_total=0x1FFFD`, `out_ovf=1`;
  - with `SUM_ACCUMULATOR_SAT_EN`: `out_total=0x3FFFF`, `out_ovf=1`.
- **Zero length:** `start` with `len=0` -> `out_valid=1` next cycle, `out_total=0`, `out_ovf=0`, no input accepted.
- **Reset mid-burst:** `len=4`, two words accepted, `rst_n` pulsed low -> all outputs zero immediately. A following `len=1` burst of 0x0005 gives `out_total=0x000005`.
- **Ignored start:** `start` with `len=7` asserted during ACCUM of a `len=2` burst -> exactly 2 words accepted, the total reflects only those, and `busy` deasserts after the output transfer.
